pio_out_pulse: RTL and testbench

Parametrised Avalon-MM output PIO for the Nios II system: drives a WIDTH-bit output port from a memory-mapped data register. It adds atomic set/clear registers and a per-bit one-shot pulse engine that inverts selected bits for a programmable number of clock cycles. It sits on the system interconnect as a zero-read-latency slave, driving board LEDs, SMA strobes and similar outputs.

---
 rtl/pio_out_pulse_pkg.sv | 15 +
 rtl/pio_out_pulse_if.sv | 29 ++
 rtl/pio_pulse_timer.sv | 34 +++
 rtl/pio_out_pulse.sv | 94 +++++++++
 tb/tb_pio_out_pulse.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_out_pulse_pkg.sv
// pio_out_pulse shared definitions: register map addresses and bus widths.
// Imported by the interface, the pulse timer and the top level.
package pio_out_pkg;

  localparam int ADDR_W = 3;
  localparam int BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PULSE    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd5;

endpackage

// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for pio_out_pulse.
// master drives address/chipselect/write_n/writedata, slave drives readdata.
interface pio_out_pulse_if
  import pio_out_pkg::*;
();

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_pulse_timer.sv
// One pulse channel: down-counter loaded with len_i on load_i, stops at 0.
// Ports: clk, reset_n, load_i, len_i[CNT_W], active_o (counter nonzero).
module pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             active_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A reload wins over the decrement, so retrigger at expiry has no gap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = len_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign active_o = (cnt_q != '0);

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with set/clear and per-bit one-shot invert pulses.
// Ports: clk, reset_n, bus (slave), out_port[WIDTH] = DATA ^ pulse_active.
module pio_out_pulse
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_out_pulse_if.slave   bus,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic             wr_data;
  logic             wr_len;
  logic             wr_set;
  logic             wr_clr;
  logic             wr_pulse;
  logic [WIDTH-1:0] wd_w;
  logic [CNT_W-1:0] wd_c;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_d;
  logic [WIDTH-1:0] ld;
  logic [WIDTH-1:0] active;
  logic [BUS_W-1:0] rd;
  logic             unused_wd;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign wr_data  = wr & (bus.address == ADDR_DATA);
  assign wr_len   = wr & (bus.address == ADDR_PULSE_LEN);
  assign wr_set   = wr & (bus.address == ADDR_OUTSET);
  assign wr_clr   = wr & (bus.address == ADDR_OUTCLEAR);
  assign wr_pulse = wr & (bus.address == ADDR_PULSE);

  assign wd_w      = bus.writedata[WIDTH-1:0];
  assign wd_c      = bus.writedata[CNT_W-1:0];
  assign unused_wd = ^bus.writedata;

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    unique case (1'b1)
      wr_data: data_d = wd_w;
      wr_set:  data_d = data_q | wd_w;
      wr_clr:  data_d = data_q & ~wd_w;
      wr_len:  len_d  = wd_c;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      len_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
    end
  end

  assign ld = {WIDTH{wr_pulse}} & wd_w;

  for (genvar g = 0; g < WIDTH; g++) begin : g_tmr
    pio_pulse_timer #(
      .CNT_W(CNT_W)
    ) u_tmr (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (ld[g]),
      .len_i   (len_q),
      .active_o(active[g])
    );
  end

  assign out_port = data_q ^ active;

  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_DATA:      rd = BUS_W'(data_q);
      ADDR_PULSE_LEN: rd = BUS_W'(len_q);
      ADDR_STATUS:    rd = BUS_W'(active);
      default:        rd = '0;
    endcase
  end

  assign bus.readdata = rd;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Self-checking bench for pio_out_pulse: directed tables and sequences
// plus random writes checked against an end-time based reference model.
module tb_pio_out_pulse;
  import pio_out_pkg::*;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_a;
  logic [0:0] out_b;

  always #5 clk = ~clk;

  pio_out_pulse_if a ();
  pio_out_pulse_if b ();

  pio_out_pulse #(
    .WIDTH(8), .CNT_W(16), .RESET_VALUE(RV)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a), .out_port(out_a)
  );

  pio_out_pulse #(
    .WIDTH(1), .CNT_W(2), .RESET_VALUE(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b), .out_port(out_b)
  );

  int errs = 0;
  int checks = 0;

  // Model: a pulse on bit i is active while cyc < end_t[i].
  logic [7:0]  data_m;
  logic [15:0] len_m;
  longint      end_t[8];
  longint      cyc = 0;

  typedef struct {
    logic [2:0]  ad;
    logic [31:0] wd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t tv[3];

  function automatic logic [7:0] act_m();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (cyc < end_t[i]);
    return r;
  endfunction

  function automatic logic [31:0] rd_m(logic [2:0] ad);
    case (ad)
      3'd0:    return {24'b0, data_m};
      3'd1:    return {16'b0, len_m};
      3'd5:    return {24'b0, act_m()};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_reset();
    data_m = RV;
    len_m  = '0;
    for (int i = 0; i < 8; i++) end_t[i] = 0;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; one clock with optional write.
  task automatic step(bit wr, logic [2:0] ad, logic [31:0] wd);
    a.chipselect = wr;
    a.write_n    = !wr;
    a.address    = ad;
    a.writedata  = wd;
    @(posedge clk);
    cyc++;
    if (wr) begin
      case (ad)
        3'd0: data_m = wd[7:0];
        3'd1: len_m  = wd[15:0];
        3'd2: data_m = data_m | wd[7:0];
        3'd3: data_m = data_m & ~wd[7:0];
        3'd4: for (int i = 0; i < 8; i++)
                if (wd[i]) end_t[i] = cyc + longint'(len_m);
        default: ;
      endcase
    end
    @(negedge clk);
    a.chipselect = 1'b0;
    a.write_n    = 1'b1;
    chk("out_port_model", {24'b0, out_a}, {24'b0, data_m ^ act_m()});
  endtask

  task automatic rd_chk(string nm, logic [2:0] ad);
    a.address = ad;
    #1;
    chk(nm, a.readdata, rd_m(ad));
  endtask

  task automatic retrig_run(int at, int exp_len);
    int len;
    bit done;
    step(1'b1, 3'd1, 32'd10);
    step(1'b1, 3'd4, 32'h1);
    len = 0;
    if (out_a[0]) len++;
    for (int j = 1; j < at; j++) begin
      step(1'b0, 3'd0, 32'h0);
      if (out_a[0]) len++;
    end
    step(1'b1, 3'd4, 32'h1);
    if (out_a[0]) len++;
    done = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      step(1'b0, 3'd0, 32'h0);
      if (out_a[0]) len++;
      else done = 1'b1;
    end
    chk("retrig_len", len, exp_len);
  endtask

  initial begin
    int len;
    bit wr;
    logic [2:0] ad;
    logic [31:0] wd;

    a.address = '0; a.chipselect = 1'b0;
    a.write_n = 1'b1; a.writedata = '0;
    b.address = '0; b.chipselect = 1'b0;
    b.write_n = 1'b1; b.writedata = '0;
    model_reset();

    tv[0] = '{3'd0, 32'h0000_000F, 8'h0F};
    tv[1] = '{3'd2, 32'h0000_0030, 8'h3F};
    tv[2] = '{3'd3, 32'h0000_0003, 8'h3C};

    @(negedge clk);
    @(negedge clk);
    chk("reset_out", {24'b0, out_a}, 32'h0000_00A5);
    reset_n = 1'b1;
    a.address = 3'd5; #1;
    chk("reset_status", a.readdata, 32'h0);
    a.address = 3'd1; #1;
    chk("reset_len", a.readdata, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, tv[i].ad, tv[i].wd);
      chk("tbl_out", {24'b0, out_a}, {24'b0, tv[i].exp_out});
    end
    a.address = 3'd0; #1;
    chk("data_rd", a.readdata, 32'h3C);
    a.address = 3'd2; #1;
    chk("outset_rd", a.readdata, 32'h0);

    step(1'b1, 3'd1, 32'd5);
    step(1'b1, 3'd0, 32'h0);
    step(1'b1, 3'd4, 32'h81);
    for (int j = 0; j < 5; j++) begin
      chk("pulse_out", {24'b0, out_a}, 32'h81);
      a.address = 3'd5; #1;
      chk("pulse_status", a.readdata, 32'h81);
      step(1'b0, 3'd0, 32'h0);
    end
    chk("pulse_end_out", {24'b0, out_a}, 32'h0);
    a.address = 3'd5; #1;
    chk("pulse_end_status", a.readdata, 32'h0);
    @(negedge clk);

    retrig_run(7, 17);
    retrig_run(9, 19);

    step(1'b1, 3'd1, 32'd0);
    step(1'b1, 3'd4, 32'hFF);
    chk("zero_idle", {24'b0, out_a}, 32'h0);
    step(1'b1, 3'd1, 32'd20);
    step(1'b1, 3'd4, 32'h01);
    chk("zero_pre", {24'b0, out_a}, 32'h01);
    step(1'b1, 3'd1, 32'd0);
    step(1'b1, 3'd4, 32'h01);
    chk("zero_kill", {24'b0, out_a}, 32'h0);

    for (int n = 0; n < 300; n++) begin
      wr = ($urandom_range(0, 2) != 0);
      ad = 3'($urandom_range(0, 7));
      wd = (ad == 3'd1) ? 32'($urandom_range(0, 12)) : $urandom;
      step(wr, ad, wd);
      rd_chk("rand_rd", 3'($urandom_range(0, 7)));
    end

    step(1'b1, 3'd1, 32'd8);
    step(1'b1, 3'd0, 32'h0);
    step(1'b1, 3'd4, 32'hFF);
    step(1'b0, 3'd0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", {24'b0, out_a}, 32'h0000_00A5);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    a.address = 3'd5; #1;
    chk("rst_status", a.readdata, 32'h0);
    a.address = 3'd1; #1;
    chk("rst_len", a.readdata, 32'h0);
    @(negedge clk);
    step(1'b0, 3'd0, 32'h0);

    b.chipselect = 1'b1; b.write_n = 1'b0;
    b.address = 3'd1; b.writedata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    b.chipselect = 1'b0; b.write_n = 1'b1;
    #1;
    chk("b_len_rd", b.readdata, 32'd3);
    b.address = 3'd6; #1;
    chk("b_addr6", b.readdata, 32'h0);
    @(negedge clk);
    b.chipselect = 1'b1; b.write_n = 1'b0;
    b.address = 3'd4; b.writedata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    b.chipselect = 1'b0; b.write_n = 1'b1;
    len = 0;
    for (int j = 0; j < 10; j++) begin
      if (out_b[0]) len++;
      @(negedge clk);
    end
    chk("b_pulse_len", len, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
